// File: rtl/sitcpxg_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the single 64-bit SiTCPXG TCP TX port.
// Latency: one cycle from an accepted source word to USER_TX_D/USER_TX_B.
// Backpressure: TX_AFULL drops SRC_READY the same cycle. A session drop flushes the frame. A stalled source aborts the frame.
//
// Ports:
//   CLK, RST                      XGMII clock, async active-high reset
//   SESSION_ESTABLISHED, TX_AFULL status from the SiTCPXG wrapper
//   SRC_VALID/DATA/BYTES/LAST     per-source word stream; SRC_READY accepts a word
//   USER_TX_D, USER_TX_B          registered word to SiTCPXG (B=0 means no write)
//   GRANT, BUSY, DROP_CNT         one-hot owner, not-idle flag, saturating abort count
module sitcpxg_tx_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SESSION_ESTABLISHED,
    input  logic                   TX_AFULL,
    input  logic [NUM_SRC-1:0]     SRC_VALID,
    input  logic [64*NUM_SRC-1:0]  SRC_DATA,
    input  logic [4*NUM_SRC-1:0]   SRC_BYTES,
    input  logic [NUM_SRC-1:0]     SRC_LAST,
    output logic [NUM_SRC-1:0]     SRC_READY,
    output logic [63:0]            USER_TX_D,
    output logic [3:0]             USER_TX_B,
    output logic [NUM_SRC-1:0]     GRANT,
    output logic                   BUSY,
    output logic [15:0]            DROP_CNT
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [SW-1:0]      STALL_MAX = SW'(STALL_TIMEOUT);
    localparam logic [NUM_SRC-1:0] ONE_HOT0  = NUM_SRC'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [63:0]        tx_d_q, tx_d_d;
    logic [3:0]         tx_b_q, tx_b_d;
    logic [15:0]        drop_q, drop_d;
    logic [SW-1:0]      stall_q, stall_d;

    // Granted source's word, selected from the one-hot grant.
    logic [IW-1:0] g_idx;
    logic          g_valid;
    logic          g_last;
    logic [63:0]   g_data;
    logic [3:0]    g_bytes;

    always_comb begin
        g_idx   = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        g_bytes = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                g_idx   = IW'(i);
                g_valid = SRC_VALID[i];
                g_last  = SRC_LAST[i];
                g_data  = SRC_DATA[64*i +: 64];
                g_bytes = SRC_BYTES[4*i +: 4];
            end
        end
    end

    // Search starts just after the last owner, so the previous owner ranks last
    // and is only re-granted when nobody else is requesting.
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_SRC;
            if (!pick_found && SRC_VALID[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    // FLUSH drains the frame regardless of TX_AFULL; its words never reach SiTCP.
    logic ready_g;
    logic accept;

    assign ready_g   = (state_q == ST_BUSY)  ? (SESSION_ESTABLISHED & ~TX_AFULL)
                                             : (state_q == ST_FLUSH);
    assign accept    = g_valid & ready_g;
    assign SRC_READY = grant_q & {NUM_SRC{ready_g}};

    logic to_idle;
    logic drop_inc;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        tx_d_d   = tx_d_q;
        tx_b_d   = 4'd0;
        drop_d   = drop_q;
        stall_d  = stall_q;
        to_idle  = 1'b0;
        drop_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (SESSION_ESTABLISHED && pick_found) begin
                    grant_d = ONE_HOT0 << pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    tx_d_d  = g_data;
                    tx_b_d  = g_bytes[3] ? 4'd8 : g_bytes;
                    stall_d = '0;
                    to_idle = g_last;
                end else if (!SESSION_ESTABLISHED) begin
                    state_d = ST_FLUSH;
                    stall_d = '0;
                end else if (stall_q == STALL_MAX) begin
                    to_idle  = 1'b1;
                    drop_inc = 1'b1;
                end else if (!g_valid) begin
                    stall_d = stall_q + SW'(1);
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    stall_d  = '0;
                    to_idle  = g_last;
                    drop_inc = g_last;
                end else if (stall_q == STALL_MAX) begin
                    to_idle  = 1'b1;
                    drop_inc = 1'b1;
                end else if (!g_valid) begin
                    stall_d = stall_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = '0;
            end
        endcase

        // Any frame end (sent or aborted) moves the round-robin pointer past the owner.
        if (to_idle) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = g_idx;
            stall_d = '0;
        end

        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NUM_SRC - 1);
            tx_d_q  <= '0;
            tx_b_q  <= '0;
            drop_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tx_d_q  <= tx_d_d;
            tx_b_q  <= tx_b_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
        end
    end

    assign USER_TX_D = tx_d_q;
    assign USER_TX_B = tx_b_q;
    assign GRANT     = grant_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// Directed bench for sitcpxg_tx_arbiter: arbitration order, AFULL, flush, stall abort,
// byte clamping and async reset, each step with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_sitcpxg_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         est;
    logic         afull;
    logic [3:0]   valid;
    logic [255:0] data;
    logic [15:0]  bytes;
    logic [3:0]   last;
    logic [3:0]   ready;
    logic [63:0]  tx_d;
    logic [3:0]   tx_b;
    logic [3:0]   grant;
    logic         busy;
    logic [15:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sitcpxg_tx_arbiter #(.NUM_SRC(4), .STALL_TIMEOUT(1023)) dut (
        .CLK                 (clk),
        .RST                 (rst),
        .SESSION_ESTABLISHED (est),
        .TX_AFULL            (afull),
        .SRC_VALID           (valid),
        .SRC_DATA            (data),
        .SRC_BYTES           (bytes),
        .SRC_LAST            (last),
        .SRC_READY           (ready),
        .USER_TX_D           (tx_d),
        .USER_TX_B           (tx_b),
        .GRANT               (grant),
        .BUSY                (busy),
        .DROP_CNT            (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input int s, input int f, input int w);
        return 64'hA500_0000_0000_0000 | (64'(s) << 32) | (64'(f) << 16) | 64'(w);
    endfunction

    task automatic put(input int s, input logic v, input logic [63:0] d,
                       input logic [3:0] b, input logic l);
        valid[s]          = v;
        data[64*s +: 64]  = d;
        bytes[4*s +: 4]   = b;
        last[s]           = l;
    endtask

    initial begin
        rst   = 1'b1;
        est   = 1'b0;
        afull = 1'b0;
        valid = '0;
        data  = '0;
        bytes = '0;
        last  = '0;

        // Reset values
        repeat (2) tick;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy",  64'(busy),  64'h0);
        chk("rst_tx_b",  64'(tx_b),  64'h0);
        chk("rst_tx_d",  tx_d,       64'h0);
        chk("rst_drop",  64'(drop_cnt), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        rst = 1'b0;
        est = 1'b1;
        tick;
        chk("idle_busy", 64'(busy), 64'h0);

        // 1: sources 0 and 2 alternate 3-word frames (8,8,5)
        put(0, 1'b1, mk(0, 0, 0), 4'd8, 1'b0);
        put(2, 1'b1, mk(2, 1, 0), 4'd8, 1'b0);
        for (int f = 0; f < 4; f++) begin
            int s;
            logic [3:0] oh;
            s  = (f % 2 == 0) ? 0 : 2;
            oh = 4'b0001 << s;
            tick;
            chk("t1_grant", 64'(grant), 64'(oh));
            chk("t1_busy",  64'(busy),  64'h1);
            chk("t1_gap_b", 64'(tx_b),  64'h0);
            chk("t1_ready", 64'(ready), 64'(oh));
            for (int w = 0; w < 3; w++) begin
                tick;
                chk("t1_d", tx_d, mk(s, f, w));
                chk("t1_b", 64'(tx_b), (w == 2) ? 64'd5 : 64'd8);
                if (w < 2) put(s, 1'b1, mk(s, f, w + 1), (w == 1) ? 4'd5 : 4'd8, w == 1);
                else       put(s, f < 2, mk(s, f + 2, 0), 4'd8, 1'b0);
            end
            chk("t1_grant_end", 64'(grant), 64'h0);
            chk("t1_busy_end",  64'(busy),  64'h0);
        end

        // 2: TX_AFULL high for 10 cycles mid-frame
        put(0, 1'b1, mk(0, 8, 0), 4'd8, 1'b0);
        tick;
        chk("t2_grant", 64'(grant), 64'h1);
        tick;
        chk("t2_d0", tx_d, mk(0, 8, 0));
        chk("t2_b0", 64'(tx_b), 64'd8);
        put(0, 1'b1, mk(0, 8, 1), 4'd8, 1'b0);
        tick;
        chk("t2_d1", tx_d, mk(0, 8, 1));
        put(0, 1'b1, mk(0, 8, 2), 4'd8, 1'b0);
        afull = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t2_ready_af", 64'(ready), 64'h0);
            tick;
            chk("t2_b_af", 64'(tx_b), 64'h0);
            chk("t2_d_af", tx_d, mk(0, 8, 1));
        end
        afull = 1'b0;
        #1;
        chk("t2_ready_resume", 64'(ready), 64'h1);
        for (int w = 2; w < 5; w++) begin
            tick;
            chk("t2_d", tx_d, mk(0, 8, w));
            chk("t2_b", 64'(tx_b), 64'd8);
            if (w < 4) put(0, 1'b1, mk(0, 8, w + 1), 4'd8, w == 3);
        end
        chk("t2_grant_end", 64'(grant), 64'h0);
        put(0, 1'b0, 64'h0, 4'd0, 1'b0);

        // 3: session drops after word 2 of a 6-word frame from source 1
        put(1, 1'b1, mk(1, 9, 0), 4'd8, 1'b0);
        tick;
        chk("t3_grant", 64'(grant), 64'h2);
        tick;
        chk("t3_b0", 64'(tx_b), 64'd8);
        put(1, 1'b1, mk(1, 9, 1), 4'd8, 1'b0);
        tick;
        chk("t3_d1", tx_d, mk(1, 9, 1));
        est = 1'b0;
        put(1, 1'b1, mk(1, 9, 2), 4'd8, 1'b0);
        #1;
        chk("t3_ready_est_low", 64'(ready), 64'h0);
        tick;
        chk("t3_flush_busy",  64'(busy),  64'h1);
        chk("t3_flush_grant", 64'(grant), 64'h2);
        chk("t3_flush_b",     64'(tx_b),  64'h0);
        afull = 1'b1;
        #1;
        chk("t3_flush_ready", 64'(ready), 64'h2);
        for (int w = 2; w < 6; w++) begin
            tick;
            chk("t3_flush_wb", 64'(tx_b), 64'h0);
            chk("t3_flush_wd", tx_d, mk(1, 9, 1));
            if (w < 5) put(1, 1'b1, mk(1, 9, w + 1), 4'd8, w == 4);
        end
        chk("t3_grant_end", 64'(grant), 64'h0);
        chk("t3_busy_end",  64'(busy),  64'h0);
        chk("t3_drop",      64'(drop_cnt), 64'd1);
        est   = 1'b1;
        afull = 1'b0;
        put(1, 1'b0, 64'h0, 4'd0, 1'b0);

        // 4: source 3 stalls 1024 cycles mid-frame; source 0 waits
        put(3, 1'b1, mk(3, 10, 0), 4'd8, 1'b0);
        tick;
        chk("t4_grant", 64'(grant), 64'h8);
        tick;
        chk("t4_b0", 64'(tx_b), 64'd8);
        put(3, 1'b0, mk(3, 10, 1), 4'd8, 1'b0);
        put(0, 1'b1, mk(0, 11, 0), 4'd12, 1'b0);
        repeat (1023) tick;
        chk("t4_stall_busy",  64'(busy),  64'h1);
        chk("t4_stall_grant", 64'(grant), 64'h8);
        chk("t4_stall_drop",  64'(drop_cnt), 64'd1);
        chk("t4_stall_b",     64'(tx_b),  64'h0);
        tick;
        chk("t4_abort_busy",  64'(busy),  64'h0);
        chk("t4_abort_grant", 64'(grant), 64'h0);
        chk("t4_abort_drop",  64'(drop_cnt), 64'd2);
        tick;
        chk("t4_next_grant", 64'(grant), 64'h1);

        // 5: bytes=12 clamps to 8; bytes=0 LAST word closes the frame
        tick;
        chk("t5_b12", 64'(tx_b), 64'd8);
        chk("t5_d12", tx_d, mk(0, 11, 0));
        put(0, 1'b1, mk(0, 11, 1), 4'd0, 1'b1);
        tick;
        chk("t5_b0",    64'(tx_b),  64'd0);
        chk("t5_d0",    tx_d,       mk(0, 11, 1));
        chk("t5_grant", 64'(grant), 64'h0);
        chk("t5_busy",  64'(busy),  64'h0);
        chk("t5_drop",  64'(drop_cnt), 64'd2);
        put(0, 1'b0, 64'h0, 4'd0, 1'b0);

        // 6: async reset mid-frame
        put(1, 1'b1, mk(1, 12, 0), 4'd8, 1'b0);
        tick;
        chk("t6_grant", 64'(grant), 64'h2);
        tick;
        chk("t6_b", 64'(tx_b), 64'd8);
        put(1, 1'b1, mk(1, 12, 1), 4'd8, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", 64'(grant), 64'h0);
        chk("t6_rst_busy",  64'(busy),  64'h0);
        chk("t6_rst_b",     64'(tx_b),  64'h0);
        chk("t6_rst_d",     tx_d,       64'h0);
        chk("t6_rst_drop",  64'(drop_cnt), 64'h0);
        chk("t6_rst_ready", 64'(ready), 64'h0);
        tick;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
